// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one external barrel shifter between two requesters
// Optional grant counters are built only when SHARB_PERF_EN is defined.
module shift_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req1_op,
    output logic [31:0]      sh_a,
    output logic [31:0]      sh_b,
    output logic [1:0]       sh_op,
    input  logic [31:0]      sh_r,
    input  logic             sh_zero,
    input  logic             sh_carry,
    input  logic             sh_negative,
    input  logic             sh_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_r,
    output logic [3:0]       rsp_flags
`ifdef SHARB_PERF_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_gnt;
    logic   gnt_valid;
    logic   gnt_id;

    // Grant decision is purely combinational so ready can follow valid in the same cycle.
    always_comb begin
        state_nxt  = state;
        gnt_valid  = 1'b0;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ~last_gnt;
                end else if (req0_valid) begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b0;
                end else if (req1_valid) begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b1;
                end
                req0_ready = gnt_valid && !gnt_id;
                req1_ready = gnt_valid && gnt_id;
                if (gnt_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            sh_a      <= 32'd0;
            sh_b      <= 32'd0;
            sh_op     <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= 32'd0;
            rsp_flags <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        sh_a     <= gnt_id ? req1_a  : req0_a;
                        sh_b     <= gnt_id ? req1_b  : req0_b;
                        sh_op    <= gnt_id ? req1_op : req0_op;
                        rsp_id   <= gnt_id;
                        last_gnt <= gnt_id;
                    end
                end
                ISSUE: begin
                    // The shifter has had the whole cycle to settle on the held operands.
                    rsp_r     <= sh_r;
                    rsp_flags <= {sh_zero, sh_carry, sh_negative, sh_overflow};
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SHARB_PERF_EN
    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_valid && req0_ready && (grant_cnt0 != {CNT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (req1_valid && req1_ready && (grant_cnt1 != {CNT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with a behavioural shifter and reference model
module tb_shift_arbiter;

    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] sh_a, sh_b, sh_r;
    logic [1:0]  sh_op;
    logic        sh_zero, sh_carry, sh_negative, sh_overflow;
    logic        rsp_valid, rsp_id;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_r;
    logic [3:0]  rsp_flags;
`ifdef SHARB_PERF_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    shift_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .sh_a(sh_a), .sh_b(sh_b), .sh_op(sh_op), .sh_r(sh_r),
        .sh_zero(sh_zero), .sh_carry(sh_carry),
        .sh_negative(sh_negative), .sh_overflow(sh_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_flags(rsp_flags)
`ifdef SHARB_PERF_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // External combinational shifter: last bit shifted out is the carry.
    function automatic logic [35:0] shifter(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [4:0]  amt;
        logic [31:0] r;
        logic        c;
        amt = a[4:0];
        c   = 1'b0;
        case (op)
            2'b00: begin r = $signed(b) >>> amt; if (amt != 0) c = b[amt - 5'd1]; end
            2'b01: begin r = b >> amt;           if (amt != 0) c = b[amt - 5'd1]; end
            default: begin r = b << amt;         if (amt != 0) c = b[32 - int'(amt)]; end
        endcase
        return {r, (r == 32'd0), c, r[31], (op[1] && (r[31] != b[31]))};
    endfunction
    assign {sh_r, sh_zero, sh_carry, sh_negative, sh_overflow} = shifter(sh_a, sh_b, sh_op);

    // Reference result from a 64-bit window: the bit just beyond the kept half is the carry.
    function automatic logic [35:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] w;
        logic [31:0] r;
        logic        c;
        if (op[1]) begin
            w = {32'd0, b} << a[4:0];
            r = w[31:0];
            c = w[32];
        end else begin
            w = (op[0]) ? ({b, 32'd0} >> a[4:0]) : 64'($signed({b, 32'd0}) >>> a[4:0]);
            r = w[63:32];
            c = w[31];
        end
        return {r, (r == 32'd0), c, r[31], (op == 2'b10 || op == 2'b11) && (r[31] != b[31])};
    endfunction

    typedef struct {
        logic        id;
        logic [31:0] r;
        logic [3:0]  f;
        int          t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    bit   busy = 1'b0;
    bit   last = 1'b1;
    bit   mon_en = 1'b0;
    bit   rsp_seen = 1'b0;
    int   gcnt0 = 0, gcnt1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy     = 1'b0;
        last     = 1'b1;
        rsp_seen = 1'b0;
        gcnt0    = 0;
        gcnt1    = 0;
    endtask

    // One cycle of stimulus: drive, then check ready against the model at the negedge.
    task automatic do_cycle(input bit v0, input bit v1,
                            input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] op0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] op1,
                            input bit rr);
        bit         e0, e1, win;
        logic [35:0] res;
        exp_t       e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = rr;
        @(negedge clk);
        e0  = 1'b0;
        e1  = 1'b0;
        win = 1'b0;
        if (!busy) begin
            if (v0 && v1) win = ~last;
            else if (v1)  win = 1'b1;
            e0 = v0 && !win;
            e1 = v1 && win;
        end
        check(req0_ready == e0, "req0_ready", 64'(req0_ready), 64'(e0));
        check(req1_ready == e1, "req1_ready", 64'(req1_ready), 64'(e1));
        if (e0 || e1) begin
            res  = win ? ref_result(a1, b1, op1) : ref_result(a0, b0, op0);
            e.id = win;
            e.r  = res[35:4];
            e.f  = res[3:0];
            e.t  = cyc;
            exp_q.push_back(e);
            busy = 1'b1;
            last = win;
            if (win) begin if (gcnt1 < (2**CNT_W) - 1) gcnt1++; end
            else     begin if (gcnt0 < (2**CNT_W) - 1) gcnt0++; end
        end else if (busy && rsp_valid && rr) begin
            busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++)
            do_cycle(1'b0, 1'b0, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), rr);
    endtask

    // Monitor: every presented response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_rsp", {31'd0, rsp_id, rsp_r}, 64'd0);
            end else begin
                check(rsp_id == exp_q[0].id, "rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                check(rsp_r == exp_q[0].r, "rsp_r", 64'(rsp_r), 64'(exp_q[0].r));
                check(rsp_flags == exp_q[0].f, "rsp_flags", 64'(rsp_flags), 64'(exp_q[0].f));
                if (!rsp_seen) begin
                    check(cyc == exp_q[0].t + 2, "rsp_latency", 64'(cyc - exp_q[0].t), 64'd2);
                    rsp_seen = 1'b1;
                end
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    rsp_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check(rsp_valid == 1'b0, "reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check({rsp_id, rsp_r, rsp_flags} == 37'd0, "reset_rsp_fields", 64'({rsp_id, rsp_r, rsp_flags}), 64'd0);
        check({sh_a, sh_b, sh_op} == 66'd0, "reset_sh_regs", {sh_a, sh_b}, 64'd0);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Reset in the middle of ISSUE drops the operation.
        do_cycle(1'b1, 1'b0, 32'd7, 32'h1234_5678, 2'b01, '0, '0, '0, 1'b1);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check(rsp_valid == 1'b0, "midissue_rsp_valid", 64'(rsp_valid), 64'd0);
        check({sh_a, sh_b} == 64'd0, "midissue_sh_cleared", {sh_a, sh_b}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(6, 1'b1);

        // Contention from reset: strict alternation starting with requester 0.
        for (int i = 0; i < 12; i++)
            do_cycle(1'b1, 1'b1, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), 1'b1);
        idle(3, 1'b1);

        // Solo srl, sra and sll corner values.
        do_cycle(1'b1, 1'b0, 32'd4, 32'h8000_0010, 2'b01, '0, '0, '0, 1'b1);
        idle(3, 1'b1);
        do_cycle(1'b0, 1'b1, '0, '0, '0, 32'd4, 32'h8000_0000, 2'b00, 1'b1);
        idle(3, 1'b1);
        do_cycle(1'b0, 1'b1, '0, '0, '0, 32'd1, 32'h8000_0000, 2'b10, 1'b1);
        idle(3, 1'b1);

        // Backpressure: response held for several cycles while both requesters wait.
        for (int i = 0; i < 8; i++)
            do_cycle(1'b1, 1'b1, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), 1'b0);
        for (int i = 0; i < 4; i++)
            do_cycle(1'b1, 1'b1, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++)
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom),
                     $urandom_range(0, 3) != 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1'b1);
        check(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef SHARB_PERF_EN
        check(grant_cnt0 == CNT_W'(gcnt0), "grant_cnt0", 64'(grant_cnt0), 64'(gcnt0));
        check(grant_cnt1 == CNT_W'(gcnt1), "grant_cnt1", 64'(grant_cnt1), 64'(gcnt1));
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
